// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
//   Tracks in-flight register writes across DEPTH pipeline stages (stage 0 is
//   the youngest) and provides operand forwarding / hazard detection for
//   NUM_RS source-register lookups.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   stall                : freeze all state (reset still applies)
//   hold                 : turn the instruction entering stage 0 into a bubble
//   flush                : kill the youngest FLUSH_DEPTH stages after the advance
//   in_valid/we/late/rd/data : instruction entering stage 0
//   late_data            : load result merged when a late entry reaches LATE_STAGE
//   rs                   : NUM_RS packed source register indices
//   fwd_hit/data/wait    : per-lookup forwarding result (youngest match wins)
//   hazard               : any lookup must wait on a late result
//   occupancy            : number of valid stages
//   bubble_count         : saturating count of held-off valid instructions
module pipe_scoreboard #(
  parameter int DEPTH       = 3,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int NUM_RS      = 2,
  parameter int LATE_STAGE  = 2,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     hold,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_we,
  input  logic                     in_late,
  input  logic [REG_W-1:0]         in_rd,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [DATA_W-1:0]        late_data,
  input  logic [NUM_RS*REG_W-1:0]  rs,
  output logic [NUM_RS-1:0]        fwd_hit,
  output logic [NUM_RS*DATA_W-1:0] fwd_data,
  output logic [NUM_RS-1:0]        fwd_wait,
  output logic                     hazard,
  output logic [3:0]               occupancy,
  output logic [15:0]              bubble_count
);

  logic [DEPTH-1:0]  st_valid;
  logic [DEPTH-1:0]  st_we;
  logic [DEPTH-1:0]  st_late;
  logic [REG_W-1:0]  st_rd   [DEPTH];
  logic [DATA_W-1:0] st_data [DEPTH];

  // Data/rd are deliberately not reset; every consumer qualifies them with valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_valid     <= '0;
      st_we        <= '0;
      st_late      <= '0;
      bubble_count <= '0;
    end else if (!stall) begin
      st_valid[0] <= in_valid & ~hold & ~flush;
      st_we[0]    <= in_we;
      st_late[0]  <= in_late;
      st_rd[0]    <= in_rd;
      st_data[0]  <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        // Flush is folded into the advance: the killed stages are the ones
        // whose new contents would otherwise land in 0..FLUSH_DEPTH-1.
        st_valid[i] <= st_valid[i-1] & ~(flush && (i < FLUSH_DEPTH));
        st_we[i]    <= st_we[i-1];
        st_rd[i]    <= st_rd[i-1];
        if ((i == LATE_STAGE) && st_valid[i-1] && st_late[i-1]) begin
          st_data[i] <= late_data;
          st_late[i] <= 1'b0;
        end else begin
          st_data[i] <= st_data[i-1];
          st_late[i] <= st_late[i-1];
        end
      end
      if (in_valid && hold && !flush && (bubble_count != 16'hFFFF))
        bubble_count <= bubble_count + 16'd1;
    end
  end

  // Oldest-to-youngest scan so the youngest match is the last one assigned.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    fwd_wait = '0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (st_valid[DEPTH-1-j] && st_we[DEPTH-1-j] &&
            (st_rd[DEPTH-1-j] == rs[k*REG_W +: REG_W]) &&
            (rs[k*REG_W +: REG_W] != '0)) begin
          fwd_hit[k]                    = 1'b1;
          fwd_data[k*DATA_W +: DATA_W]  = st_data[DEPTH-1-j];
          fwd_wait[k]                   = st_late[DEPTH-1-j];
        end
      end
    end
  end

  assign hazard = |fwd_wait;

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      occupancy = occupancy + 4'(st_valid[i]);
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, hold = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_we = 1'b0, in_late = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0, late_data = '0;
  logic [9:0]  rs = '0;
  logic [1:0]  fwd_hit, fwd_wait;
  logic [63:0] fwd_data;
  logic        hazard;
  logic [3:0]  occupancy;
  logic [15:0] bubble_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_scoreboard #(
    .DEPTH(3), .DATA_W(32), .REG_W(5), .NUM_RS(2), .LATE_STAGE(2), .FLUSH_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_we(in_we), .in_late(in_late), .in_rd(in_rd),
    .in_data(in_data), .late_data(late_data), .rs(rs),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_wait(fwd_wait),
    .hazard(hazard), .occupancy(occupancy), .bubble_count(bubble_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic enter(input logic [4:0] rd, input logic [31:0] data, input logic late);
    in_valid = 1'b1; in_we = 1'b1; in_late = late; in_rd = rd; in_data = data;
    tick();
    in_valid = 1'b0; in_we = 1'b0; in_late = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1;
    // Reset state
    do_reset();
    rs = {5'd3, 5'd5};
    #1;
    check("rst_hit", 64'(fwd_hit), 64'd0);
    check("rst_data", fwd_data, 64'd0);
    check("rst_wait", 64'(fwd_wait), 64'd0);
    check("rst_hazard", 64'(hazard), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_bubble", 64'(bubble_count), 64'd0);

    // Youngest match wins
    enter(5'd5, 32'h11, 1'b0);
    enter(5'd5, 32'h22, 1'b0);
    rs = {5'd0, 5'd5};
    #1;
    check("prio_hit0", 64'(fwd_hit[0]), 64'd1);
    check("prio_data0", 64'(fwd_data[31:0]), 64'h22);
    check("prio_hit1_rs0", 64'(fwd_hit[1]), 64'd0);
    check("prio_occ", 64'(occupancy), 64'd2);
    tick();
    check("prio_aged_data0", 64'(fwd_data[31:0]), 64'h22);
    check("prio_aged_occ", 64'(occupancy), 64'd2);

    // rd=0 tracked but never forwarded
    do_reset();
    enter(5'd0, 32'h99, 1'b0);
    rs = {5'd0, 5'd0};
    #1;
    check("r0_hit0", 64'(fwd_hit[0]), 64'd0);
    check("r0_data0", 64'(fwd_data[31:0]), 64'd0);
    check("r0_occ", 64'(occupancy), 64'd1);

    // Late merge at LATE_STAGE
    do_reset();
    rs = {5'd7, 5'd0};
    enter(5'd7, 32'h1, 1'b1);
    check("late_s0_wait1", 64'(fwd_wait[1]), 64'd1);
    check("late_s0_hazard", 64'(hazard), 64'd1);
    check("late_s0_hit1", 64'(fwd_hit[1]), 64'd1);
    late_data = 32'hDEAD;
    tick();
    check("late_s1_wait1", 64'(fwd_wait[1]), 64'd1);
    tick();
    check("late_s2_data1", 64'(fwd_data[63:32]), 64'hDEAD);
    check("late_s2_wait1", 64'(fwd_wait[1]), 64'd0);
    check("late_s2_hazard", 64'(hazard), 64'd0);
    check("late_s2_hit1", 64'(fwd_hit[1]), 64'd1);

    // Older ready match must not mask a younger late one
    do_reset();
    enter(5'd7, 32'h33, 1'b0);
    enter(5'd7, 32'h44, 1'b1);
    check("mask_wait1", 64'(fwd_wait[1]), 64'd1);
    check("mask_hazard", 64'(hazard), 64'd1);
    check("mask_data1", 64'(fwd_data[63:32]), 64'h44);

    // Flush kills the two youngest stages after the advance
    do_reset();
    enter(5'd1, 32'h1, 1'b0);
    enter(5'd2, 32'h2, 1'b0);
    enter(5'd3, 32'h3, 1'b0);
    check("flush_fill_occ", 64'(occupancy), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_we = 1'b1; in_rd = 5'd4; in_data = 32'h4;
    tick();
    flush = 1'b0; in_valid = 1'b0; in_we = 1'b0;
    rs = {5'd3, 5'd2};
    #1;
    check("flush_occ", 64'(occupancy), 64'd1);
    check("flush_hit0", 64'(fwd_hit[0]), 64'd1);
    check("flush_data0", 64'(fwd_data[31:0]), 64'h2);
    check("flush_hit1", 64'(fwd_hit[1]), 64'd0);
    check("flush_bubble", 64'(bubble_count), 64'd0);

    // Stall freezes everything, including flush/hold/in_valid
    stall = 1'b1; flush = 1'b1; hold = 1'b1; in_valid = 1'b1; in_we = 1'b1;
    in_rd = 5'd3; late_data = 32'hBEEF;
    repeat (3) tick();
    check("stall_occ", 64'(occupancy), 64'd1);
    check("stall_hit", 64'(fwd_hit), 64'b01);
    check("stall_data", fwd_data, 64'h2);
    check("stall_bubble", 64'(bubble_count), 64'd0);

    // Hold injects a bubble and counts it
    stall = 1'b0; flush = 1'b0;
    tick();
    check("hold_bubble1", 64'(bubble_count), 64'd1);
    check("hold_occ", 64'(occupancy), 64'd0);

    // Saturation, then reset overriding stall
    repeat (65539) tick();
    check("sat_bubble", 64'(bubble_count), 64'hFFFF);
    stall = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0; hold = 1'b0; in_valid = 1'b0;
    check("sat_rst_bubble", 64'(bubble_count), 64'd0);
    check("sat_rst_occ", 64'(occupancy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning the number of tracked pipeline stages (stage 0 youngest; legal range 2..8).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the result data width.
REQ-003 SHALL have parameter REG_W, default 5, meaning the register index width.
REQ-004 SHALL have parameter NUM_RS, default 2, meaning the number of source-lookup ports.
REQ-005 SHALL have parameter LATE_STAGE, default 2, meaning the stage whose entry captures late (load) data; 1 <= LATE_STAGE <= DEPTH-1.
REQ-006 SHALL have parameter FLUSH_DEPTH, default 2, meaning the number of youngest stages killed by flush; 1 <= FLUSH_DEPTH <= DEPTH.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have ports stall (input, 1, freeze all state) and hold (input, 1, inject a bubble into stage 0).
REQ-010 SHALL have port flush, input, 1, kill the youngest FLUSH_DEPTH stages.
REQ-011 SHALL have ports in_valid (1), in_we (1), in_late (1), in_rd (REG_W) and in_data (DATA_W), all inputs, describing the instruction entering stage 0.
REQ-012 SHALL have port late_data, input, DATA_W, the result merged at LATE_STAGE.
REQ-013 SHALL have ports rs (input, NUM_RS*REG_W), fwd_hit (output, NUM_RS), fwd_data (output, NUM_RS*DATA_W) and fwd_wait (output, NUM_RS); port k occupies slice k.
REQ-014 SHALL have ports hazard (output, 1), occupancy (output, 4) and bubble_count (output, 16).

Function
REQ-015 Each stage SHALL hold valid, we, late, rd and data fields.
REQ-016 SHALL do nothing on an edge with stall=1 other than reset; flush, hold, in_* and late_data are ignored that cycle.
REQ-017 SHALL advance, on an edge with stall=0: stage[i] <= stage[i-1] for i >= 1, and stage[0] <= {in_valid & ~hold, in_we, in_late, in_rd, in_data}.
REQ-018 SHALL replace data with late_data and clear late when an entry advances into LATE_STAGE with late=1 and valid=1, in the same advance.
REQ-019 SHALL clear valid in stages 0..FLUSH_DEPTH-1 after the advance when flush=1 and stall=0; flush overrides hold and in_valid.
REQ-020 SHALL, for each port k, combinationally compute a match when valid & we & rd == rs[k] & rs[k] != 0; the youngest (lowest-index) matching stage wins.
REQ-021 SHALL drive fwd_hit[k]=1 and fwd_data[k]=the winner's data on a match; otherwise fwd_hit[k]=0 and fwd_data[k]=0.
REQ-022 SHALL drive fwd_wait[k]=1 when the winner has late=1; an older ready match SHALL NOT mask a younger late one.
REQ-023 SHALL drive hazard = OR of fwd_wait, combinationally.
REQ-024 SHALL drive occupancy = the count of valid stages, combinationally, with range 0..DEPTH.
REQ-025 SHALL increment bubble_count on every non-stalled edge where in_valid=1 and hold=1, saturating at 16'hFFFF; flush SHALL NOT increment it.
REQ-026 SHALL treat register 0 as never matching; writes to rd=0 are tracked but never forwarded.

Reset
REQ-027 SHALL, on an edge with reset=1, clear all valid, we and late flags and set bubble_count=0; reset overrides stall, flush and hold.
REQ-028 SHALL output after reset: fwd_hit=0, fwd_data=0, fwd_wait=0, hazard=0, occupancy=0 and bubble_count=0.
REQ-029 SHALL leave data and rd fields unconstrained by reset; no output may depend on them while valid=0.

Verification
REQ-030 Forwarding priority: enter rd=5/data=0x11, then rd=5/data=0x22; with rs[0]=5, fwd_hit[0]=1 and fwd_data[0]=0x22.
REQ-031 Late merge: enter rd=7 with in_late=1; while it sits in stage 0 with rs[1]=7, fwd_wait[1]=1 and hazard=1; advance with late_data=0xDEAD until it reaches LATE_STAGE, then fwd_data[1]=0xDEAD and fwd_wait[1]=0.
REQ-032 Flush: fill all 3 stages (occupancy=3), then pulse flush with in_valid=1; next cycle occupancy=1, with only the former stage-1 entry, now in stage 2, valid.
REQ-033 Stall precedence: with stall=1, assert flush, hold and in_valid for 3 cycles; all outputs remain unchanged and bubble_count remains 0.
REQ-034 Saturation and reset: apply hold=1 and in_valid=1 for 65540 cycles; bubble_count=0xFFFF; then assert reset with stall=1; next cycle bubble_count=0 and occupancy=0.
REQ-035 rd=0: enter rd=0 with in_we=1; with rs[0]=0, fwd_hit[0]=0 and fwd_data[0]=0.
